// File: rtl/decoder_n_scan.sv
// rtl/decoder_n_scan.sv - registered N-to-2^N one-hot decoder with walking-one scan mode
module decoder_n_scan #(
    parameter int N          = 3,
    parameter int SCAN_DIV   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      d,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      idx,
    output logic              valid,
    output logic              wrap
);

    localparam int OUT_W = 2**N;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     idx_next;

    assign idx_next = idx + 1'b1;

    // Polarity is applied here so y is always a pure register of the line pattern.
    function automatic logic [OUT_W-1:0] lines(input logic [N-1:0] sel);
        logic [OUT_W-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            div   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            y     <= INACTIVE;
        end else if (!en) begin
            state <= IDLE;
            div   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            y     <= INACTIVE;
        end else if (!mode) begin
            state <= DECODE;
            idx   <= d;
            y     <= lines(d);
            div   <= '0;
            valid <= 1'b1;
            wrap  <= 1'b0;
        end else if (state != SCAN) begin
            // Entering scan always reloads from d; there is no resume.
            state <= SCAN;
            idx   <= d;
            y     <= lines(d);
            div   <= '0;
            valid <= 1'b1;
            wrap  <= 1'b0;
        end else if (div == DIV_LAST) begin
            idx   <= idx_next;
            y     <= lines(idx_next);
            div   <= '0;
            valid <= 1'b1;
            wrap  <= (idx == '1);
        end else begin
            div   <= div + 1'b1;
            valid <= 1'b1;
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_n_scan.sv
// tb/tb_decoder_n_scan.sv - randomized and directed check of decoder_n_scan against a cycle-count model
module tb_decoder_n_scan;

    logic       clk = 1'b0;
    logic       rst, en, mode;
    logic [2:0] d;
    logic [7:0] y0, y1;
    logic [2:0] idx0, idx1;
    logic       valid0, valid1, wrap0, wrap1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_n_scan #(.N(3), .SCAN_DIV(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .y(y0), .idx(idx0), .valid(valid0), .wrap(wrap0)
    );

    decoder_n_scan #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .y(y1), .idx(idx1), .valid(valid1), .wrap(wrap1)
    );

    // Model: scan index derived from start index and cycles elapsed since entry.
    int divs[2] = '{4, 1};
    int als[2]  = '{0, 1};
    int m_idx[2], m_start[2], m_k[2];
    bit m_scan[2], m_valid[2], m_wrap[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_y(input int u);
        logic [7:0] v;
        v = m_valid[u] ? 8'(1 << m_idx[u]) : 8'h00;
        return (als[u] != 0) ? ~v : v;
    endfunction

    task automatic model_update(input bit r, input bit e, input bit m, input int dv);
        for (int u = 0; u < 2; u++) begin
            m_wrap[u] = 1'b0;
            if (r) begin
                m_idx[u] = 0; m_valid[u] = 0; m_scan[u] = 0;
            end else if (!e) begin
                m_valid[u] = 0; m_scan[u] = 0;
            end else if (!m) begin
                m_idx[u] = dv; m_valid[u] = 1; m_scan[u] = 0;
            end else begin
                if (!m_scan[u]) begin
                    m_scan[u] = 1; m_start[u] = dv; m_k[u] = 0;
                end else begin
                    m_k[u]++;
                end
                m_valid[u] = 1;
                m_idx[u]   = (m_start[u] + m_k[u] / divs[u]) % 8;
                m_wrap[u]  = (m_k[u] > 0) && (m_k[u] % divs[u] == 0) && (m_idx[u] == 0);
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit m, input int dv);
        rst = r; en = e; mode = m; d = 3'(dv);
        @(posedge clk);
        #1;
        model_update(r, e, m, dv);
        chk("y_d4",     32'(y0),     32'(exp_y(0)));
        chk("idx_d4",   32'(idx0),   32'(m_idx[0]));
        chk("valid_d4", 32'(valid0), 32'(m_valid[0]));
        chk("wrap_d4",  32'(wrap0),  32'(m_wrap[0]));
        chk("y_al",     32'(y1),     32'(exp_y(1)));
        chk("idx_al",   32'(idx1),   32'(m_idx[1]));
        chk("valid_al", 32'(valid1), 32'(m_valid[1]));
        chk("wrap_al",  32'(wrap1),  32'(m_wrap[1]));
    endtask

    initial begin
        int dd;
        bit ee, mm, rr;
        rst = 1'b1; en = 1'b1; mode = 1'b1; d = 3'd5;

        // Reset with scan request pending
        step(1, 1, 1, 5);
        step(1, 1, 1, 5);
        chk("rst_y", 32'(y0), 32'h00);
        chk("rst_y_al", 32'(y1), 32'hFF);

        // Decode sequence
        step(0, 1, 0, 0);
        step(0, 1, 0, 2);
        step(0, 1, 0, 4);
        step(0, 1, 0, 5);
        step(0, 1, 0, 7);
        chk("dec_d7", 32'(y0), 32'h80);

        // Decode then disable
        step(0, 1, 0, 3);
        chk("dec_d3", 32'(y0), 32'h08);
        step(0, 0, 0, 3);
        chk("dis_y", 32'(y0), 32'h00);

        // Scan entry at 6, through wrap, to 1
        step(0, 1, 1, 6);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0);
        chk("s_idx7", 32'(idx0), 32'd7);
        step(0, 1, 1, 0);
        chk("s_wrap", 32'(wrap0), 32'd1);
        chk("s_idx0", 32'(idx0), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        chk("s_idx1", 32'(idx0), 32'd1);

        // Drop enable mid-scan, re-enable reloads from d
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 2);
        chk("reload_idx", 32'(idx0), 32'd2);
        step(0, 1, 1, 2);
        chk("reload_next", 32'(idx0), 32'd3);

        // Active-low, single-cycle divider: wrap on ninth cycle from d=0
        step(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 1, 0);
        chk("al_wrap", 32'(wrap1), 32'd1);
        chk("al_y", 32'(y1), 32'hFE);

        // Mode switch scan -> decode -> scan
        step(0, 1, 0, 4);
        step(0, 1, 1, 1);
        step(0, 1, 1, 7);

        // Randomized traffic
        mm = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 59) == 0);
            ee = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 11) == 0) mm = ~mm;
            dd = int'($urandom_range(0, 7));
            step(rr, ee, mm, dd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
